phase_sequencer: RTL

Parametrised multi-cycle phase controller for the ARM32 core, replacing the fixed fetch/regread/mem/regwrite1/regwrite2 counter. It steps each instruction through only the phases the decoder marks as needed. It holds the memory phase on a wait-state handshake, raises a faulted state on decode or memory-timeout faults, and keeps cycle, instruction and stall counters for the debug ports.

---
 rtl/phase_sequencer.sv | 83 ++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: mask-driven multi-cycle phase controller with memory wait-states, fault state and debug counters
module phase_sequencer #(
  parameter int NUM_PHASES  = 5,
  parameter int PHASE_W     = 3,
  parameter int FAULT_PHASE = 2**PHASE_W-1,
  parameter int MEM_PHASE   = 2,
  parameter int MAX_WAIT    = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  run,
  input  logic [NUM_PHASES-1:0] phase_mask,
  input  logic                  fault_req,
  input  logic                  mem_ready,
  input  logic                  fault_clr,
  output logic [PHASE_W-1:0]    phase,
  output logic                  mem_req,
  output logic                  pc_update,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      instr_count,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int WW = $clog2(MAX_WAIT+1);
  localparam logic [PHASE_W-1:0] FP = PHASE_W'(FAULT_PHASE);
  localparam logic [PHASE_W-1:0] MP = PHASE_W'(MEM_PHASE);
  localparam logic [PHASE_W-1:0] LP = PHASE_W'(NUM_PHASES);
  logic [WW-1:0] wait_cnt;
  logic [PHASE_W-1:0] nxt;
  logic found, active, in_fault, wait_low, timeout, stall;
  // lowest enabled phase above the current one; bits 0 and 1 never qualify
  always_comb begin
    nxt = '0;
    found = 1'b0;
    for (int i = NUM_PHASES-1; i >= 1; i--)
      if (PHASE_W'(i) > phase && phase_mask[i]) begin
        nxt = PHASE_W'(i);
        found = 1'b1;
      end
  end
  assign active    = phase != '0 && phase < LP;
  assign in_fault  = phase == FP;
  assign wait_low  = phase == MP && !mem_ready;
  assign timeout   = wait_low && wait_cnt == WW'(MAX_WAIT);
  assign stall     = wait_low && !timeout && !fault_req;
  assign mem_req   = phase == MP;
  assign fault     = in_fault;
  assign pc_update = active && !fault_req && !wait_low && !found;
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      phase       <= '0;
      fault_cause <= 2'b00;
      wait_cnt    <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      cycle_count <= (phase == '0 && !run) || in_fault ? cycle_count : cycle_count + CNT_W'(1);
      instr_count <= pc_update ? instr_count + CNT_W'(1) : instr_count;
      stall_count <= stall ? stall_count + CNT_W'(1) : stall_count;
      wait_cnt    <= stall ? wait_cnt + WW'(1) : '0;
      if (phase == '0)
        phase <= run ? PHASE_W'(1) : '0;
      else if (in_fault) begin
        if (fault_clr) begin
          phase       <= '0;
          fault_cause <= 2'b00;
        end
      end else if (!active)
        phase <= '0;
      else if (fault_req) begin
        phase       <= FP;
        fault_cause <= 2'b01;
      end else if (timeout) begin
        phase       <= FP;
        fault_cause <= 2'b10;
      end else if (!stall)
        phase <= found ? nxt : '0;
    end
  end
endmodule
